decode_issue: RTL and testbench
===============================

# decode_issue

Decode and operand-fetch stage directly upstream of the ALU. Accepts 32-bit RV32 instructions over a valid/ready handshake and buffers one in a single-entry slot. Reads operands from an internal 32x32 register file and holds the instruction while a scoreboard reports a register hazard. Issues a registered {datain, datain2, opcode} triple that the ALU captures on the following clock edge. The writeback port from the downstream stage updates the register file and clears scoreboard bits.

## Interface
- XLEN, 32: datapath width.
- NREG, 32: architectural register count; x0 reads as zero.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  slot can accept this cycle.
- in_instr  in  32  RV32 instruction word.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- out_valid  out  1  issue pulse, one cycle per instruction.
- datain  out  32  ALU operand A.
- datain2  out  32  ALU operand B.
- opcode  out  7  ALU operation code.
- out_rd  out  5  destination register of the issued instruction.
- illegal  out  1  one-cycle pulse when an unsupported instruction is dropped.

## Operation
- Decode, ALU code:
  - ADD (op 0110011, f3 000, f7 0000000) → 0, operands rs1/rs2.
  - MUL (op 0110011, f3 000, f7 0000001) → 2, operands rs1/rs2.
  - LW (op 0000011, f3 010) → 3, operands rs1/sext(imm[11:0]).
  - ADDI (op 0010011, f3 000) → 4, operands rs1/sext(imm[11:0]).
  - Any other word is illegal.
- FSM states:
  - EMPTY: in_ready=1. in_valid moves to HELD and captures in_instr.
  - HELD: no hazard → issue. If in_valid is high in the same cycle, capture the new word and stay HELD; otherwise go to EMPTY.
  - HELD with hazard: stay. in_ready=0.
  - in_ready = EMPTY | (HELD & can_issue).
- Illegal word in HELD: consumed immediately without hazard check. illegal=1, out_valid=0, busy is unchanged.
- Hazard: busy[rs1], busy[rs2] (R-type only) or busy[rd] (WAW) is set, and that bit is not being cleared by the writeback in the same cycle. Fields with index 0 never hazard.
- Issue:
  - Register datain/datain2/opcode/out_rd and set out_valid=1 for one cycle.
  - Set busy[rd] if rd≠0.
- Writeback with wb_en and wb_rd≠0:
  - Write regfile[wb_rd] and clear busy[wb_rd].
  - A read of the same register in the same cycle returns wb_data (bypass).
  - wb_rd=0 is ignored.
- Same cycle issue-set and writeback-clear on one register: the set wins.
- Immediates are sign-extended to XLEN. No arithmetic is performed here.

## Timing
- Accept at edge E0. Earliest issue at E1 (out_valid high during E1→E2). ALU result is available after E2.
- Sustained throughput is one instruction per cycle when hazard-free.
- out_valid and illegal are single-cycle pulses. The ALU never back-pressures.
- Reset values, asserted asynchronously at any time including mid-stall:
  - FSM → EMPTY.
  - busy=0 and all regfile entries=0.
  - out_valid=0, illegal=0.
  - datain, datain2, opcode and out_rd all 0.
  - in_ready=1 after reset deasserts.
  - An instruction held when reset asserts is discarded.
- In-flight instructions are never aborted except by reset.

## Structure
- Shared package `riscv_pkg`:
  - RV32 major opcode constants and funct3/funct7 constants.
  - ALU code constants ALU_ADD=0, ALU_MUL=2, ALU_LW=3, ALU_ADDI=4, shared with the ALU.
  - FSM state enum.
- Sub-module `reg_file`:
  - 2 read ports and 1 write port.
  - Asynchronous reset to zero.
  - x0 hardwired to zero.
  - Write-to-read bypass.
- The scoreboard and FSM stay in the top module.

## Test plan
- Setup: reset, then writeback x1=5 and x2=7.
- ADD: in_instr=0x002081B3 (add x3,x1,x2) → one cycle later out_valid=1, datain=5, datain2=7, opcode=0, out_rd=3.
- ADDI: 0xFFF00213 (addi x4,x0,-1) → datain=0, datain2=0xFFFFFFFF, opcode=4, out_rd=4.
- RAW stall:
  - Issue add x3, then 0x023182B3 (mul x5,x3,x3) → in_ready=0 and no out_valid while busy[3] is set.
  - Apply wb x3=12 → issue in the next cycle with datain=datain2=12, opcode=2.
- LW: 0x0080A303 (lw x6,8(x1)) → datain=5, datain2=8, opcode=3, out_rd=6.
- Illegal: 0xFFFFFFFF → illegal pulse, out_valid stays 0, and the next valid instruction issues normally.
- Reset and x0:
  - Assert rst during a RAW stall → all outputs 0 immediately and in_ready=1 after release. A subsequent add x3,x1,x2 reads 0,0.
  - Writeback to x0 with data 9 → x0 still reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, ALU operation codes and issue-slot state.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [6:0] ALU_ADD  = 7'd0;
    localparam logic [6:0] ALU_MUL  = 7'd2;
    localparam logic [6:0] ALU_LW   = 7'd3;
    localparam logic [6:0] ALU_ADDI = 7'd4;

    typedef enum logic {
        ST_EMPTY,
        ST_HELD
    } state_e;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file; x0 reads zero, writes bypass to same-cycle reads.
module reg_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    output logic [XLEN-1:0] rd1_o,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_ok;

    assign wr_ok = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (wr_ok && wa_i == ra1_i) rd1_o = wd_i;
        if (wr_ok && wa_i == ra2_i) rd2_o = wd_i;
        if (ra1_i == 5'd0) rd1_o = '0;
        if (ra2_i == 5'd0) rd2_o = '0;
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/operand-fetch stage: single-entry slot, scoreboard hazard stall,
// registered operand/opcode issue to the ALU.
module decode_issue
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [XLEN-1:0] datain,
    output logic [XLEN-1:0] datain2,
    output logic [6:0]      opcode,
    output logic [4:0]      out_rd,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            out_valid_q, illegal_q;
    logic [XLEN-1:0] opa_q, opb_q;
    logic [6:0]      alu_q;
    logic [4:0]      rd_q;

    logic [4:0]      rs1, rs2, rd;
    logic [6:0]      op, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] rdata1, rdata2, opb;
    logic            is_add, is_mul, is_lw, is_addi;
    logic            legal, rtype;
    logic [6:0]      alu;
    logic [NREG-1:0] wb_clr, busy_eff;
    logic            held, hazard, issue, drop, accept;

    assign op  = instr_q[6:0];
    assign rd  = instr_q[11:7];
    assign f3  = instr_q[14:12];
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign f7  = instr_q[31:25];

    reg_file u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1),
        .rd1_o (rdata1),
        .ra2_i (rs2),
        .rd2_o (rdata2),
        .we_i  (wb_en),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    assign is_add  = op == OP_REG  && f3 == F3_ADD && f7 == F7_BASE;
    assign is_mul  = op == OP_REG  && f3 == F3_ADD && f7 == F7_MUL;
    assign is_lw   = op == OP_LOAD && f3 == F3_LW;
    assign is_addi = op == OP_IMM  && f3 == F3_ADD;

    always_comb begin
        legal = 1'b1;
        rtype = 1'b0;
        alu   = ALU_ADD;
        unique case (1'b1)
            is_add:  begin rtype = 1'b1; alu = ALU_ADD;  end
            is_mul:  begin rtype = 1'b1; alu = ALU_MUL;  end
            is_lw:   alu = ALU_LW;
            is_addi: alu = ALU_ADDI;
            default: legal = 1'b0;
        endcase
    end

    assign opb = rtype ? rdata2 : sext12(instr_q[31:20]);

    // A writeback landing this cycle already releases its register.
    assign wb_clr   = (wb_en && wb_rd != 5'd0) ? (NREG'(1) << wb_rd) : '0;
    assign busy_eff = busy_q & ~wb_clr;

    assign hazard = (rs1 != 5'd0 && busy_eff[rs1])
                  | (rtype && rs2 != 5'd0 && busy_eff[rs2])
                  | (rd != 5'd0 && busy_eff[rd]);

    assign held     = state_q == ST_HELD;
    assign issue    = held && legal && !hazard;
    assign drop     = held && !legal;
    assign in_ready = !held || issue || drop;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        if (accept) begin
            state_d = ST_HELD;
            instr_d = in_instr;
        end else if (issue || drop) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        busy_d = busy_eff;
        if (issue && rd != 5'd0) busy_d[rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            instr_q     <= '0;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            busy_q      <= busy_d;
            out_valid_q <= issue;
            illegal_q   <= drop;
            if (issue) begin
                opa_q <= rdata1;
                opb_q <= opb;
                alu_q <= alu;
                rd_q  <= rd;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign datain    = opa_q;
    assign datain2   = opb_q;
    assign opcode    = alu_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: operand fetch, hazards, illegal drop, reset.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic [31:0] datain, datain2;
    logic [6:0]  opcode;
    logic [4:0]  out_rd;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    decode_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .datain    (datain),
        .datain2   (datain2),
        .opcode    (opcode),
        .out_rd    (out_rd),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1; in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [6:0] op,
                             input logic [4:0] r);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".a"}, datain, a);
        chk({tag, ".b"}, datain2, b);
        chk({tag, ".op"}, 32'(opcode), 32'(op));
        chk({tag, ".rd"}, 32'(out_rd), 32'(r));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);

        // add x3,x1,x2
        send(32'h002081B3);
        chk("add.e0", 32'(out_valid), 32'd0);
        tick();
        chk_issue("add", 32'd5, 32'd7, 7'd0, 5'd3);
        tick();
        chk("add.pulse", 32'(out_valid), 32'd0);

        // addi x4,x0,-1
        send(32'hFFF00213);
        tick();
        chk_issue("addi", 32'd0, 32'hFFFFFFFF, 7'd4, 5'd4);

        // mul x5,x3,x3 stalls on busy x3
        send(32'h023182B3);
        chk("raw.ready0", 32'(in_ready), 32'd0);
        chk("raw.novalid0", 32'(out_valid), 32'd0);
        tick();
        chk("raw.ready1", 32'(in_ready), 32'd0);
        chk("raw.novalid1", 32'(out_valid), 32'd0);
        tick();
        chk("raw.novalid2", 32'(out_valid), 32'd0);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd12;
        #1;
        chk("raw.wbready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        chk_issue("mul", 32'd12, 32'd12, 7'd2, 5'd5);

        // lw x6,8(x1)
        send(32'h0080A303);
        tick();
        chk_issue("lw", 32'd5, 32'd8, 7'd3, 5'd6);

        // illegal word dropped, then addi x7,x0,5
        send(32'hFFFFFFFF);
        tick();
        chk("ill.pulse", 32'(illegal), 32'd1);
        chk("ill.novalid", 32'(out_valid), 32'd0);
        send(32'h00500393);
        chk("ill.clear", 32'(illegal), 32'd0);
        tick();
        chk_issue("post_ill", 32'd0, 32'd5, 7'd4, 5'd7);

        // back-to-back addi x8,x0,1 ; addi x9,x0,2
        in_valid = 1'b1; in_instr = 32'h00100413;
        tick();
        in_instr = 32'h00200493;
        #1;
        chk("b2b.ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_issue("b2b0", 32'd0, 32'd1, 7'd4, 5'd8);
        tick();
        chk_issue("b2b1", 32'd0, 32'd2, 7'd4, 5'd9);

        // mul x5 stalls on WAW x5, then reset mid-stall
        send(32'h023182B3);
        chk("waw.ready", 32'(in_ready), 32'd0);
        tick();
        chk("waw.novalid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst2.a", datain, 32'd0);
        chk("rst2.b", datain2, 32'd0);
        chk("rst2.op", 32'(opcode), 32'd0);
        chk("rst2.rd", 32'(out_rd), 32'd0);
        chk("rst2.valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        chk("rst2.ready", 32'(in_ready), 32'd1);
        tick();
        chk("rst2.discard", 32'(out_valid), 32'd0);
        send(32'h002081B3);
        tick();
        chk_issue("add_rst", 32'd0, 32'd0, 7'd0, 5'd3);

        // x0 write ignored, even while read in the same cycle
        wb(5'd1, 32'd21);
        send(32'h00000513);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        chk_issue("x0", 32'd0, 32'd0, 7'd4, 5'd10);
        // add x11,x0,x1 after x0 write
        send(32'h001005B3);
        tick();
        chk_issue("x0b", 32'd0, 32'd21, 7'd0, 5'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
